alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width; only 32 is required to work.
REQ-002 clk  input  1  single clock; rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 busA  input  32  first operand; the shift source for SL/SR.
REQ-005 busB  input  32  second operand; bits [4:0] are the shift amount for SL/SR.
REQ-006 operation  input  5  opcode.
REQ-007 result  output  32  operation result.
REQ-008 z  output  1  zero flag.
REQ-009 n  output  1  negative flag.
REQ-010 c  output  1  carry flag.
REQ-011 v  output  1  signed-overflow flag.

Function
REQ-012 Opcodes SHALL be:
- 0x01 LD: result = busA.
- 0x02 MOV: result = busB.
- 0x03 ADD: result = busA + busB.
- 0x04 SUB: result = busA - busB.
- 0x05 AND, 0x06 OR, 0x07 XOR: bitwise on busA and busB.
- 0x08 NOT: result = ~busA.
- 0x09 SL: busA logical-shift-left by busB[4:0].
- 0x0A SR: busA logical-shift-right by busB[4:0].
REQ-013 Opcode 0x00 and opcodes 0x0B-0x1F SHALL give result = 0 and z = n = c = v = 0.
REQ-014 For every defined opcode, z SHALL be 1 exactly when result == 0.
REQ-015 For every defined opcode, n SHALL equal result[31].
REQ-016 ADD flags: c = carry out of bit 31; v = 1 when both operands have the same sign and the result sign differs from it.
REQ-017 SUB SHALL be computed as busA + ~busB + 1.
REQ-018 SUB flags: c = carry out of bit 31, i.e. c = 1 when busA >= busB unsigned (no borrow); v = 1 when the operand signs differ and the result sign differs from busA.
REQ-019 SL flags: c = last bit shifted out, busA[32 - busB[4:0]]; c = 0 when the shift amount is 0; v = 0.
REQ-020 SR flags: c = 0 and v = 0 for every shift amount.
REQ-021 Logic, NOT, LD and MOV SHALL clear c and v.
REQ-022 Without ALU_REG_OUT_EN, result and the flags SHALL be purely combinational from busA, busB and operation, with zero latency; clk SHALL then be unused.

Reset
REQ-023 While rst = 1, result SHALL be 0 and z, n, c, v SHALL be 0, asynchronously, in both configurations.
REQ-024 When rst is released, the outputs SHALL reflect the current inputs: immediately in the combinational build, at the next rising clk edge in the registered build.

Configuration
REQ-025 Macro ALU_REG_OUT_EN defined: result and z, n, c, v SHALL be registered on the rising clk edge, giving a latency of 1 cycle, with registers cleared asynchronously by rst.
REQ-026 Macro ALU_REG_OUT_EN undefined: REQ-022 applies.

Structure
REQ-027 Package alu_pkg SHALL hold the opcode constants (OP_LD through OP_SR) and the WIDTH default.
REQ-028 Sub-module alu_core SHALL hold the combinational datapath and flag logic.
REQ-029 The top module alu SHALL contain only the reset gating and the optional output registers.

Verification (combinational build, rst = 0 unless stated)
REQ-030 LD: busA = 0x0F0F0F0F, op 0x01 -> result 0x0F0F0F0F; z = n = c = v = 0.
REQ-031 ADD cases:
- 2 + 5, op 0x03 -> result 7, all flags 0.
- 0x7FFFFFFF + 1 -> result 0x80000000, n = 1, v = 1, c = 0, z = 0.
REQ-032 SUB cases:
- 5 - 3, op 0x04 -> result 2, c = 1, others 0.
- 3 - 5 -> result 0xFFFFFFFE, n = 1, c = 0, v = 0.
REQ-033 Logic cases:
- AND 0xF0F0F0F0 & 0x0F0F0F0F -> result 0, z = 1.
- OR of the same operands -> result 0xFFFFFFFF, n = 1.
- XOR 0xF0F0F00F ^ 0x0F0F0F0F -> result 0xFFFFFF00.
- NOT 0xFFFF0000 -> result 0x0000FFFF, all flags 0.
REQ-034 Shift cases:
- SL 0x80000001 by 1 -> result 0x00000002, c = 1.
- SR 0x80000001 by 1 -> result 0x40000000, all flags 0.
- Opcode 0x1F -> result 0, all flags 0.
REQ-035 Reset: assert rst during ADD of 0x7FFFFFFF + 1 -> result 0 and all flags 0 immediately. Registered build: after rst is released, the outputs update on the next clk edge.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants and types for the ALU slice.
//   WIDTH_DEFAULT : default datapath width (only 32 is exercised)
//   OP_LD..OP_SR  : 5-bit opcode encodings
//   flags_t       : packed {z, n, c, v} status flags
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [4:0] OP_LD  = 5'h01;
  localparam logic [4:0] OP_MOV = 5'h02;
  localparam logic [4:0] OP_ADD = 5'h03;
  localparam logic [4:0] OP_SUB = 5'h04;
  localparam logic [4:0] OP_AND = 5'h05;
  localparam logic [4:0] OP_OR  = 5'h06;
  localparam logic [4:0] OP_XOR = 5'h07;
  localparam logic [4:0] OP_NOT = 5'h08;
  localparam logic [4:0] OP_SL  = 5'h09;
  localparam logic [4:0] OP_SR  = 5'h0A;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational datapath and flag generation.
//   busA      : first operand, shift source
//   busB      : second operand, [4:0] is the shift amount
//   operation : 5-bit opcode (alu_pkg::OP_*)
//   result    : operation result (0 for undefined opcodes)
//   flags     : {z, n, c, v}; all zero for undefined opcodes
// ---------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic [4:0]       operation,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [WIDTH:0]   sl_wide;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  logic             defined;

  assign shamt   = busB[4:0];
  assign add_sum = {1'b0, busA} + {1'b0, busB};
  // Subtract as A + ~B + 1 so the top bit is the "no borrow" carry.
  assign sub_sum = {1'b0, busA} + {1'b0, ~busB} + {{WIDTH{1'b0}}, 1'b1};
  // One extra bit above the operand catches the last bit shifted out;
  // a zero shift leaves that bit clear, which is the required carry.
  assign sl_wide = {1'b0, busA} << shamt;

  always_comb begin
    res     = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    defined = 1'b1;
    case (operation)
      OP_LD:  res = busA;
      OP_MOV: res = busB;
      OP_ADD: begin
        res   = add_sum[MSB:0];
        carry = add_sum[WIDTH];
        ovf   = (busA[MSB] == busB[MSB]) && (res[MSB] != busA[MSB]);
      end
      OP_SUB: begin
        res   = sub_sum[MSB:0];
        carry = sub_sum[WIDTH];
        ovf   = (busA[MSB] != busB[MSB]) && (res[MSB] != busA[MSB]);
      end
      OP_AND: res = busA & busB;
      OP_OR:  res = busA | busB;
      OP_XOR: res = busA ^ busB;
      OP_NOT: res = ~busA;
      OP_SL: begin
        res   = sl_wide[MSB:0];
        carry = sl_wide[WIDTH];
      end
      OP_SR:  res = busA >> shamt;
      default: defined = 1'b0;
    endcase
  end

  assign result  = res;
  assign flags.z = defined && (res == '0);
  assign flags.n = defined && res[MSB];
  assign flags.c = carry;
  assign flags.v = ovf;

endmodule

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu (top)
// Reset gating and optional output registers around alu_core.
//   clk       : rising-edge clock (only used when ALU_REG_OUT_EN is defined)
//   rst       : asynchronous active-high reset; forces outputs to zero
//   busA/busB : operands
//   operation : 5-bit opcode
//   result    : operation result
//   z/n/c/v   : zero, negative, carry, signed-overflow flags
// Build option: define ALU_REG_OUT_EN to register result and flags
// (1-cycle latency); otherwise outputs are combinational.
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic [4:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  logic [WIDTH-1:0] core_result;
  flags_t           core_flags;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .busA      (busA),
    .busB      (busB),
    .operation (operation),
    .result    (core_result),
    .flags     (core_flags)
  );

`ifdef ALU_REG_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      z      <= 1'b0;
      n      <= 1'b0;
      c      <= 1'b0;
      v      <= 1'b0;
    end else begin
      result <= core_result;
      z      <= core_flags.z;
      n      <= core_flags.n;
      c      <= core_flags.c;
      v      <= core_flags.v;
    end
  end
`else
  // Clock has no function in the combinational build.
  logic unused_clk;
  assign unused_clk = clk;

  always_comb begin
    result = '0;
    z      = 1'b0;
    n      = 1'b0;
    c      = 1'b0;
    v      = 1'b0;
    if (!rst) begin
      result = core_result;
      z      = core_flags.z;
      n      = core_flags.n;
      c      = core_flags.c;
      v      = core_flags.v;
    end
  end
`endif

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
// Self-checking bench for alu. A reference model computes result/flags
// from plain arithmetic; a compare process checks every falling edge, and
// directed cases pin the model with literal values. Works in both builds
// (define ALU_REG_OUT_EN for the registered one).
// ---------------------------------------------------------------------------
module tb_alu;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] busA;
  logic [W-1:0] busB;
  logic [4:0]   operation;
  logic [W-1:0] result;
  logic         z, n, c, v;

  int tests;
  int fails;

  // Expected vector layout: {result, z, n, c, v}
  logic [W+3:0] exp_reg;
  logic [W+3:0] exp_q[$];
  string        name_q[$];
  bit           check_en;

  alu dut (
    .clk       (clk),
    .rst       (rst),
    .busA      (busA),
    .busB      (busB),
    .operation (operation),
    .result    (result),
    .z         (z),
    .n         (n),
    .c         (c),
    .v         (v)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W+3:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [4:0]   op);
    longint unsigned s;
    logic [W-1:0]    r;
    logic            cf, vf;
    int              sh;
    r  = '0;
    cf = 1'b0;
    vf = 1'b0;
    sh = int'(b[4:0]);
    case (op)
      5'h01: r = a;
      5'h02: r = b;
      5'h03: begin
        s  = longint'(a) + longint'(b);
        r  = s[31:0];
        cf = (s >= 64'h1_0000_0000);
        vf = (a[31] == b[31]) && (r[31] != a[31]);
      end
      5'h04: begin
        r  = a - b;
        cf = (a >= b);
        vf = (a[31] != b[31]) && (r[31] != a[31]);
      end
      5'h05: r = a & b;
      5'h06: r = a | b;
      5'h07: r = a ^ b;
      5'h08: r = ~a;
      5'h09: begin
        r  = a << sh;
        cf = (sh == 0) ? 1'b0 : a[32 - sh];
      end
      5'h0A: r = a >> sh;
      default: return '0;
    endcase
    return {r, (r == '0), r[31], cf, vf};
  endfunction

  function automatic logic [W+3:0] expected_now();
    if (rst) return '0;
`ifdef ALU_REG_OUT_EN
    return exp_reg;
`else
    return model(busA, busB, operation);
`endif
  endfunction

  // Registered build: what the output registers should hold after an edge.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_reg <= '0;
    else     exp_reg <= model(busA, busB, operation);
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [W+3:0] exp;
    if (check_en) begin
      exp = expected_now();
      tests++;
      if ({result, z, n, c, v} !== exp) begin
        fails++;
        $display("FAIL model_cmp op=%h a=%h b=%h rst=%0b: got r=%h znvc=%b%b%b%b exp r=%h znvc=%b",
                 operation, busA, busB, rst, result, z, n, c, v,
                 exp[W+3:4], exp[3:0]);
      end
    end
  end

  // ---------------- driver / literal checks ----------------
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] op);
    @(posedge clk);
    #1;
    busA      = a;
    busB      = b;
    operation = op;
  endtask

  task automatic check_lit(input string nm, input logic [W+3:0] exp);
    tests++;
    if ({result, z, n, c, v} !== exp) begin
      fails++;
      $display("FAIL %s: got r=%h znvc=%b%b%b%b exp r=%h znvc=%b",
               nm, result, z, n, c, v, exp[W+3:4], exp[3:0]);
    end
  endtask

  // Apply a directed case and check its literal outcome once it is visible.
  task automatic directed(input string nm, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] op,
                          input logic [W+3:0] exp);
    drive(a, b, op);
`ifdef ALU_REG_OUT_EN
    @(posedge clk);
    #1;
`endif
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    #1;
    check_lit(name_q.pop_front(), exp_q.pop_front());
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] a, b;
    logic [W-1:0] corner[4];
    tests     = 0;
    fails     = 0;
    check_en  = 1'b0;
    rst       = 1'b1;
    busA      = 32'h7FFF_FFFF;
    busB      = 32'h0000_0001;
    operation = 5'h03;
    corner[0] = 32'h0000_0000;
    corner[1] = 32'h7FFF_FFFF;
    corner[2] = 32'h8000_0000;
    corner[3] = 32'hFFFF_FFFF;

    #3;
    check_lit("reset_state", '0);
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Literal expectations: {result, z, n, c, v}
    directed("ld",        32'h0F0F0F0F, 32'h0,        5'h01, {32'h0F0F0F0F, 4'b0000});
    directed("add_small", 32'd2,        32'd5,        5'h03, {32'd7,        4'b0000});
    directed("add_ovf",   32'h7FFFFFFF, 32'd1,        5'h03, {32'h80000000, 4'b0101});
    directed("sub_pos",   32'd5,        32'd3,        5'h04, {32'd2,        4'b0010});
    directed("sub_neg",   32'd3,        32'd5,        5'h04, {32'hFFFFFFFE, 4'b0100});
    directed("and_zero",  32'hF0F0F0F0, 32'h0F0F0F0F, 5'h05, {32'h0,        4'b1000});
    directed("or_ones",   32'hF0F0F0F0, 32'h0F0F0F0F, 5'h06, {32'hFFFFFFFF, 4'b0100});
    directed("xor",       32'hF0F0F00F, 32'h0F0F0F0F, 5'h07, {32'hFFFFFF00, 4'b0100});
    directed("not",       32'hFFFF0000, 32'h0,        5'h08, {32'h0000FFFF, 4'b0000});
    directed("sl_carry",  32'h80000001, 32'd1,        5'h09, {32'h00000002, 4'b0010});
    directed("sl_zero",   32'h80000001, 32'd0,        5'h09, {32'h80000001, 4'b0100});
    directed("sr",        32'h80000001, 32'd1,        5'h0A, {32'h40000000, 4'b0000});
    directed("op_1f",     32'h12345678, 32'h9ABCDEF0, 5'h1F, {32'h0,        4'b0000});
    directed("op_00",     32'hFFFFFFFF, 32'hFFFFFFFF, 5'h00, {32'h0,        4'b0000});
    directed("sub_eq",    32'h80000000, 32'h80000000, 5'h04, {32'h0,        4'b1010});

    // Asynchronous reset during ADD 0x7FFFFFFF + 1.
    drive(32'h7FFFFFFF, 32'd1, 5'h03);
`ifdef ALU_REG_OUT_EN
    @(posedge clk);
    #1;
`endif
    #1;
    rst = 1'b1;
    #1;
    check_lit("rst_async", '0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
`ifdef ALU_REG_OUT_EN
    check_lit("rst_hold", '0);
    @(posedge clk);
    #1;
    check_lit("rst_release", {32'h80000000, 4'b0101});
`else
    check_lit("rst_release", {32'h80000000, 4'b0101});
`endif

    // Randomized stimulus, biased toward corner operands.
    repeat (3000) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      drive(a, b, 5'($urandom_range(0, 31)));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
